// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Aurora TX AXI-Stream link between NUM_SRC producers.
// Optional build macro AURORA_TX_ARB_SEQ_APPEND_EN appends a sequence word after every good packet.
module aurora_tx_arbiter #(
  parameter int          NUM_SRC       = 2,
  parameter int          MAX_BEATS     = 256,
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] ABORT_WORD    = 32'hDEAD_0000
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  input  logic [32*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [15:0]           pkt_count
);

  localparam int BEAT_W  = $clog2(MAX_BEATS + 1);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_ABORT,
    S_DRAIN
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
    , S_SEQ
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [2:0]           grant_nxt, last_grant, last_nxt;
  logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
  logic [STALL_W-1:0]   stall_cnt, stall_nxt;
  logic [15:0]          pkt_nxt;
  logic                 err_nxt;
  logic                 g_valid, g_last, at_max, rr_found;
  logic [31:0]          g_data;
  logic [2:0]           rr_pick;
  int                   rr_dist, rr_best;

`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
  logic [15:0] seq_ctr, seq_nxt;

  // Sequence numbers skip zero so a receiver can treat 0 as "no sequence".
  function automatic logic [15:0] seq_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'h0001 : v + 16'h0001;
  endfunction
`endif

  assign busy   = (state != S_IDLE);
  assign at_max = (beat_cnt == BEAT_W'(MAX_BEATS - 1));

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 3'(i)) begin
        g_valid = s_axis_tvalid[i];
        g_data  = s_axis_tdata[32*i +: 32];
        g_last  = s_axis_tlast[i];
      end
    end
  end

  // Round-robin: smallest rotated distance from last_grant+1 wins.
  always_comb begin
    rr_dist  = 0;
    rr_best  = NUM_SRC;
    rr_pick  = last_grant;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rr_dist = i - int'(last_grant) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NUM_SRC;
      if (s_axis_tvalid[i] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_pick  = 3'(i);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_id;
    last_nxt      = last_grant;
    beat_nxt      = beat_cnt;
    stall_nxt     = stall_cnt;
    pkt_nxt       = pkt_count;
    err_nxt       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
    seq_nxt       = seq_ctr;
`endif
    case (state)
      S_IDLE: begin
        if (rr_found) begin
          grant_nxt = rr_pick;
          beat_nxt  = '0;
          stall_nxt = '0;
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        m_axis_tvalid = g_valid;
        m_axis_tdata  = g_data;
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
        m_axis_tlast  = at_max && !g_last;
`else
        m_axis_tlast  = g_last || at_max;
`endif
        for (int i = 0; i < NUM_SRC; i++)
          s_axis_tready[i] = (grant_id == 3'(i)) && m_axis_tready;
        if (g_valid && m_axis_tready) begin
          stall_nxt = '0;
          beat_nxt  = beat_cnt + 1'b1;
          if (g_last) begin
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
            state_nxt = S_SEQ;
`else
            pkt_nxt   = pkt_count + 16'd1;
            last_nxt  = grant_id;
            state_nxt = S_IDLE;
`endif
          end else if (at_max) begin
            err_nxt   = 1'b1;
            state_nxt = S_DRAIN;
          end
        end else if (!g_valid) begin
          // Only a silent source counts toward the stall; downstream backpressure does not.
          if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
            stall_nxt = '0;
            err_nxt   = 1'b1;
            state_nxt = S_ABORT;
          end else begin
            stall_nxt = stall_cnt + 1'b1;
          end
        end
      end
      S_ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = ABORT_WORD;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        for (int i = 0; i < NUM_SRC; i++)
          s_axis_tready[i] = (grant_id == 3'(i));
        if (g_valid && g_last) begin
          last_nxt  = grant_id;
          state_nxt = S_IDLE;
        end
      end
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
      S_SEQ: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {16'h0000, seq_ctr};
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          seq_nxt   = seq_inc(seq_ctr);
          pkt_nxt   = pkt_count + 16'd1;
          last_nxt  = grant_id;
          state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state      <= S_IDLE;
      grant_id   <= '0;
      last_grant <= 3'(NUM_SRC - 1);
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      pkt_count  <= '0;
      err_pulse  <= 1'b0;
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
      seq_ctr    <= 16'h0001;
`endif
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= beat_nxt;
      stall_cnt  <= stall_nxt;
      pkt_count  <= pkt_nxt;
      err_pulse  <= err_nxt;
`ifdef AURORA_TX_ARB_SEQ_APPEND_EN
      seq_ctr    <= seq_nxt;
`endif
    end
  end

endmodule
